agc_loop_ctrl: RTL and testbench

AGC_LOOP_CTRL -- requirements
Module: agc_loop_ctrl

---
 rtl/agc_loop_ctrl.sv | 174 +++++++++++++++++
 tb/tb_agc_loop_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_loop_ctrl.sv
`timescale 1ns/1ps
// agc_loop_ctrl: automatic gain control loop sequencer.
// Periodically requests a power estimate, converts the dB error against the
// target into a clamped gain step, tracks lock, and flags missed estimates.
module agc_loop_ctrl #(
    parameter int unsigned PERIOD     = 1024,
    parameter int unsigned SETTLE     = 64,
    parameter logic [7:0]  GAIN_INIT  = 8'd128,
    parameter logic [7:0]  GAIN_MIN   = 8'd0,
    parameter logic [7:0]  GAIN_MAX   = 8'd255,
    parameter int unsigned STEP_SHIFT = 2,
    parameter logic [8:0]  DEADBAND   = 9'd2,
    parameter logic [8:0]  LOCK_WIN   = 9'd6,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       agc_en,
    input  logic [8:0] target_dB,
    input  logic [8:0] pwr_est_dB,
    input  logic       pwr_est_end,
    output logic       log_start,
    output logic [7:0] gain_code,
    output logic       gain_valid,
    output logic       agc_lock,
    output logic       est_timeout
);

    // One shared cycle counter serves WAIT, EST and SETTLE; it is sized for
    // the longest of the three.
    localparam int unsigned CNT_MAX =
        (PERIOD > SETTLE) ? ((PERIOD > TIMEOUT) ? PERIOD : TIMEOUT)
                          : ((SETTLE > TIMEOUT) ? SETTLE : TIMEOUT);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] PERIOD_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_FULL    = LW'(LOCK_CNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_EST,
        ST_UPD,
        ST_SETTLE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   lock_cnt;
    logic [LW-1:0]   lock_next;
    logic [8:0]      est_cap;

    logic signed [9:0]  err;
    logic [9:0]         err_mag;
    logic [9:0]         step_mag;
    logic signed [9:0]  delta;
    logic signed [10:0] gain_sum;
    logic [7:0]         gain_next;
    logic               in_deadband;
    logic               in_lock_win;

    // Next-state logic; a low agc_en overrides every state.
    // NOTE: next_state is given its default before any branch so no path
    // through this block leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        if (!agc_en) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   next_state = ST_WAIT;
                ST_WAIT:   if (cnt == PERIOD_LAST) next_state = ST_REQ;
                ST_REQ:    next_state = ST_EST;
                ST_EST: begin
                    if (pwr_est_end)              next_state = ST_UPD;
                    else if (cnt == TIMEOUT_LAST) next_state = ST_WAIT;
                end
                ST_UPD:    next_state = ST_SETTLE;
                ST_SETTLE: if (cnt == SETTLE_LAST) next_state = ST_WAIT;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Error-to-gain datapath evaluated during UPD from the captured estimate.
    // The shift acts on the magnitude so positive and negative errors round
    // the same way (toward zero), and any error outside the deadband moves
    // the gain by at least one code.
    always_comb begin
        err         = {1'b0, target_dB} - {1'b0, est_cap};
        err_mag     = err[9] ? $unsigned(-err) : $unsigned(err);
        in_deadband = (err_mag <= {1'b0, DEADBAND});
        in_lock_win = (err_mag <= {1'b0, LOCK_WIN});

        step_mag = err_mag >> STEP_SHIFT;
        if (step_mag == 10'd0) step_mag = 10'd1;

        if (in_deadband)  delta = '0;
        else if (err[9])  delta = -$signed(step_mag);
        else              delta = $signed(step_mag);

        gain_sum = $signed({3'b000, gain_code}) + $signed({delta[9], delta});
        if (gain_sum < $signed({3'b000, GAIN_MIN}))      gain_next = GAIN_MIN;
        else if (gain_sum > $signed({3'b000, GAIN_MAX})) gain_next = GAIN_MAX;
        else                                             gain_next = gain_sum[7:0];

        if (!in_lock_win)            lock_next = '0;
        else if (lock_cnt == LOCK_FULL) lock_next = lock_cnt;
        else                         lock_next = lock_cnt + LW'(1);
    end

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Shared cycle counter: restarts on every state change and rests in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                    cnt <= '0;
        else if (next_state != state || state == ST_IDLE) cnt <= '0;
        else                                             cnt <= cnt + CW'(1);
    end

    // Registered outputs, lock tracking and estimate capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            log_start   <= 1'b0;
            gain_code   <= GAIN_INIT;
            gain_valid  <= 1'b0;
            agc_lock    <= 1'b0;
            est_timeout <= 1'b0;
            lock_cnt    <= '0;
            est_cap     <= '0;
        end else begin
            log_start  <= (next_state == ST_REQ);
            gain_valid <= 1'b0;
            if (!agc_en) begin
                agc_lock    <= 1'b0;
                est_timeout <= 1'b0;
                lock_cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: gain_code <= GAIN_INIT;
                    ST_EST: begin
                        if (pwr_est_end) begin
                            est_cap <= pwr_est_dB;
                        end else if (cnt == TIMEOUT_LAST) begin
                            est_timeout <= 1'b1;
                            lock_cnt    <= '0;
                            agc_lock    <= 1'b0;
                        end
                    end
                    ST_UPD: begin
                        gain_code  <= gain_next;
                        gain_valid <= 1'b1;
                        lock_cnt   <= lock_next;
                        agc_lock   <= (lock_next == LOCK_FULL);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_agc_loop_ctrl.sv
`timescale 1ns/1ps
// tb_agc_loop_ctrl: directed bench for agc_loop_ctrl with default parameters.
module tb_agc_loop_ctrl;

    localparam int PERIOD  = 1024;
    localparam int SETTLE  = 64;
    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       agc_en = 1'b0;
    logic [8:0] target_dB = '0;
    logic [8:0] pwr_est_dB = '0;
    logic       pwr_est_end = 1'b0;
    logic       log_start;
    logic [7:0] gain_code;
    logic       gain_valid;
    logic       agc_lock;
    logic       est_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gv_count = 0;
    int ls_count = 0;

    // Saturation sequence: target, estimate, gain expected after the update.
    logic [8:0] sat_tgt [5] = '{9'd504, 9'd40, 9'd0,   9'd0,   9'd0};
    logic [8:0] sat_est [5] = '{9'd0,   9'd0,  9'd508, 9'd508, 9'd40};
    logic [7:0] sat_gain[5] = '{8'd254, 8'd255, 8'd128, 8'd1,  8'd0};

    agc_loop_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .agc_en      (agc_en),
        .target_dB   (target_dB),
        .pwr_est_dB  (pwr_est_dB),
        .pwr_est_end (pwr_est_end),
        .log_start   (log_start),
        .gain_code   (gain_code),
        .gain_valid  (gain_valid),
        .agc_lock    (agc_lock),
        .est_timeout (est_timeout)
    );

    always #5 clk = ~clk;

    // Cycle and pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        cyc++;
        if (gain_valid === 1'b1) gv_count++;
        if (log_start === 1'b1)  ls_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log_start(input int max_cyc, input string tag, output int waited);
        waited = 0;
        while (log_start !== 1'b1 && waited < max_cyc) begin
            tick();
            waited++;
        end
        n_checks++;
        if (log_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: log_start absent after %0d cycles, expected a pulse", tag, max_cyc);
        end
    endtask

    // Estimator model: answers n cycles after the log_start cycle.
    task automatic est_reply(input int n, input logic [8:0] db);
        repeat (n) tick();
        pwr_est_end = 1'b1;
        pwr_est_dB  = db;
        tick();
        pwr_est_end = 1'b0;
    endtask

    task automatic restart();
        agc_en = 1'b0;
        tick();
        tick();
        agc_en = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL reset_gain: got %0d want 128", gain_code); end
        n_checks++; if (log_start !== 1'b0) begin n_fail++; $display("FAIL reset_log_start: got %b want 0", log_start); end
        n_checks++; if (gain_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gain_valid: got %b want 0", gain_valid); end
        n_checks++; if (agc_lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", agc_lock); end
        n_checks++; if (est_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", est_timeout); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_loop();
        int w;
        int c1;
        int gv0;
        target_dB = 9'd200;
        restart();
        // A stray estimate during WAIT must be ignored.
        repeat (10) tick();
        pwr_est_end = 1'b1;
        pwr_est_dB  = 9'd0;
        tick();
        pwr_est_end = 1'b0;
        wait_log_start(1200, "basic_first_req", w);
        n_checks++; if (w + 11 !== 1025) begin n_fail++; $display("FAIL basic_first_latency: got %0d want 1025", w + 11); end
        c1  = cyc;
        gv0 = gv_count;
        est_reply(11, 9'd180);
        n_checks++; if (gain_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", gain_valid); end
        n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL basic_gain_before: got %0d want 128", gain_code); end
        tick();
        n_checks++; if (gain_code !== 8'd133) begin n_fail++; $display("FAIL basic_gain: got %0d want 133", gain_code); end
        n_checks++; if (gain_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", gain_valid); end
        tick();
        n_checks++; if (gain_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width: got %b want 0", gain_valid); end
        wait_log_start(1200, "basic_second_req", w);
        n_checks++; if (cyc - c1 !== PERIOD + 1 + 11 + 1 + SETTLE) begin n_fail++; $display("FAIL basic_interval: got %0d want %0d", cyc - c1, PERIOD + 13 + SETTLE); end
        n_checks++; if (gv_count - gv0 !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d want 1", gv_count - gv0); end
    endtask

    task automatic test_deadband_lock();
        int w;
        int gv0;
        logic exp_lock;
        target_dB = 9'd200;
        restart();
        gv0 = gv_count;
        for (int i = 0; i < 4; i++) begin
            exp_lock = (i == 3);
            wait_log_start(1200, "lock_req", w);
            est_reply(5, 9'd199);
            tick();
            n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL lock_gain_%0d: got %0d want 128", i, gain_code); end
            n_checks++; if (agc_lock !== exp_lock) begin n_fail++; $display("FAIL lock_flag_%0d: got %b want %b", i, agc_lock, exp_lock); end
        end
        tick();
        n_checks++; if (gv_count - gv0 !== 4) begin n_fail++; $display("FAIL lock_valid_count: got %0d want 4", gv_count - gv0); end
        wait_log_start(1200, "unlock_req", w);
        est_reply(5, 9'd210);
        tick();
        n_checks++; if (gain_code !== 8'd126) begin n_fail++; $display("FAIL unlock_gain: got %0d want 126", gain_code); end
        n_checks++; if (agc_lock !== 1'b0) begin n_fail++; $display("FAIL unlock_flag: got %b want 0", agc_lock); end
        n_checks++; if (gain_valid !== 1'b1) begin n_fail++; $display("FAIL unlock_valid: got %b want 1", gain_valid); end
    endtask

    task automatic test_saturation();
        int w;
        restart();
        for (int i = 0; i < 5; i++) begin
            target_dB = sat_tgt[i];
            wait_log_start(1200, "sat_req", w);
            est_reply(3, sat_est[i]);
            tick();
            n_checks++; if (gain_code !== sat_gain[i]) begin n_fail++; $display("FAIL sat_gain_%0d: got %0d want %0d", i, gain_code, sat_gain[i]); end
        end
    endtask

    task automatic test_small_error();
        int w;
        target_dB = 9'd100;
        restart();
        tick();
        n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL reload_gain: got %0d want 128", gain_code); end
        wait_log_start(1200, "small_req", w);
        est_reply(3, 9'd103);
        tick();
        n_checks++; if (gain_code !== 8'd127) begin n_fail++; $display("FAIL small_neg_gain: got %0d want 127", gain_code); end
        target_dB = 9'd103;
        wait_log_start(1200, "small_req2", w);
        est_reply(3, 9'd100);
        tick();
        n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL small_pos_gain: got %0d want 128", gain_code); end
    endtask

    task automatic test_timeout();
        int w;
        int t;
        int c1;
        int gv0;
        target_dB = 9'd200;
        restart();
        wait_log_start(1200, "to_req", w);
        c1  = cyc;
        gv0 = gv_count;
        t   = 0;
        while (est_timeout !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        n_checks++; if (t !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", t, TIMEOUT + 1); end
        n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL to_gain: got %0d want 128", gain_code); end
        wait_log_start(1200, "to_next_req", w);
        n_checks++; if (cyc - c1 !== PERIOD + 1 + TIMEOUT) begin n_fail++; $display("FAIL to_interval: got %0d want %0d", cyc - c1, PERIOD + 1 + TIMEOUT); end
        n_checks++; if (est_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", est_timeout); end
        n_checks++; if (gv_count !== gv0) begin n_fail++; $display("FAIL to_no_valid: got %0d want %0d", gv_count, gv0); end
        agc_en = 1'b0;
        tick();
        n_checks++; if (est_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", est_timeout); end
    endtask

    task automatic test_abort();
        int w;
        int gv0;
        int ls0;
        target_dB = 9'd200;
        restart();
        wait_log_start(1200, "abort_req", w);
        repeat (5) tick();
        gv0 = gv_count;
        ls0 = ls_count;
        // agc_en falls on the same cycle the estimate arrives, then a late one.
        agc_en      = 1'b0;
        pwr_est_end = 1'b1;
        pwr_est_dB  = 9'd0;
        tick();
        pwr_est_end = 1'b0;
        repeat (3) tick();
        pwr_est_end = 1'b1;
        tick();
        pwr_est_end = 1'b0;
        repeat (1200) tick();
        n_checks++; if (gv_count !== gv0) begin n_fail++; $display("FAIL abort_valid: got %0d want %0d", gv_count, gv0); end
        n_checks++; if (ls_count !== ls0) begin n_fail++; $display("FAIL abort_idle_req: got %0d want %0d", ls_count, ls0); end
        n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL abort_gain: got %0d want 128", gain_code); end
    endtask

    task automatic test_reset_in_settle();
        int w;
        int gv0;
        int ls0;
        target_dB = 9'd200;
        restart();
        wait_log_start(1200, "rst_req", w);
        est_reply(11, 9'd180);
        tick();
        n_checks++; if (gain_code !== 8'd133) begin n_fail++; $display("FAIL rst_pre_gain: got %0d want 133", gain_code); end
        repeat (10) tick();
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (gain_code !== 8'd128) begin n_fail++; $display("FAIL rst_async_gain: got %0d want 128", gain_code); end
        n_checks++; if (log_start !== 1'b0) begin n_fail++; $display("FAIL rst_async_log_start: got %b want 0", log_start); end
        n_checks++; if (gain_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", gain_valid); end
        n_checks++; if (agc_lock !== 1'b0) begin n_fail++; $display("FAIL rst_async_lock: got %b want 0", agc_lock); end
        n_checks++; if (est_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_async_timeout: got %b want 0", est_timeout); end
        agc_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        gv0 = gv_count;
        ls0 = ls_count;
        repeat (50) tick();
        n_checks++; if (ls_count !== ls0 || gv_count !== gv0) begin n_fail++; $display("FAIL rst_quiet: got %0d/%0d pulses want 0/0", ls_count - ls0, gv_count - gv0); end
    endtask

    initial begin
        test_reset();
        test_basic_loop();
        test_deadband_lock();
        test_saturation();
        test_small_error();
        test_timeout();
        test_abort();
        test_reset_in_settle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
